srff_bank_ctrl: RTL and testbench

Arbitrated controller for a bank of SR-style flag registers. Up to NREQ requesters issue set/reset commands against individual flags. A round-robin arbiter serializes the commands and applies each one with SR flip-flop semantics (00 hold, 10 set, 01 reset, 11 illegal). Each transfer completes with a four-phase req/ack handshake. The block sits between control agents and the shared status-flag bank, replacing ad-hoc direct drive of the SR flip-flops.

---
 rtl/srff_bank_ctrl.sv | 166 ++++++++++++++++
 tb/tb_srff_bank_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/srff_bank_ctrl.sv
// srff_bank_ctrl: round-robin arbitrated set/reset controller for a flag bank.
// Define SRFF_CTRL_TOGGLE_EN to make s=r=1 toggle the flag instead of raising err.
module srff_bank_ctrl #(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int IW    = 3
) (
   input  logic               clk,
   input  logic               res,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    cmd_s,
   input  logic [NREQ-1:0]    cmd_r,
   input  logic [NREQ*IW-1:0] cmd_idx,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    ack,
   output logic [NFLAG-1:0]   q,
   output logic               err,
   output logic               busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RELEASE
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_n;
   logic [PW-1:0]    win;
   logic [PW-1:0]    win_n;
   logic             ls;
   logic             ls_n;
   logic             lr;
   logic             lr_n;
   logic [IW-1:0]    lidx;
   logic [IW-1:0]    lidx_n;
   logic [NREQ-1:0]  gnt_n;
   logic [NREQ-1:0]  ack_n;
   logic [NFLAG-1:0] q_n;
   logic             err_n;
   logic             found;
   logic [PW-1:0]    pick;
   logic             win_req;

   assign busy = (state != IDLE);

   // Round-robin search: first requester at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[(int'(ptr) + k) % NREQ]) begin
            found = 1'b1;
            pick  = PW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   // Current winner's request line, watched during RELEASE.
   always_comb begin
      win_req = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (PW'(i) == win) begin
            win_req = req[i];
         end
      end
   end

   // Next-state and next-output logic for the transfer FSM.
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      win_n   = win;
      ls_n    = ls;
      lr_n    = lr;
      lidx_n  = lidx;
      gnt_n   = gnt;
      ack_n   = ack;
      q_n     = q;
      err_n   = err;
      unique case (state)
         IDLE: begin
            if (found) begin
               win_n = pick;
               gnt_n = '0;
               for (int i = 0; i < NREQ; i++) begin
                  if (PW'(i) == pick) begin
                     gnt_n[i] = 1'b1;
                     ls_n     = cmd_s[i];
                     lr_n     = cmd_r[i];
                     lidx_n   = cmd_idx[i*IW +: IW];
                  end
               end
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (int'(lidx) >= NFLAG) begin
               err_n = 1'b1;
            end else begin
               for (int f = 0; f < NFLAG; f++) begin
                  if (int'(lidx) == f) begin
                     case ({ls, lr})
                        2'b10: q_n[f] = 1'b1;
                        2'b01: q_n[f] = 1'b0;
                        2'b11: begin
`ifdef SRFF_CTRL_TOGGLE_EN
                           q_n[f] = ~q[f];
`else
                           err_n  = 1'b1;
`endif
                        end
                        default: q_n[f] = q[f];
                     endcase
                  end
               end
            end
            ack_n   = gnt;
            state_n = RELEASE;
         end
         RELEASE: begin
            if (!win_req) begin
               gnt_n   = '0;
               ack_n   = '0;
               ptr_n   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State, latched command and output registers.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state <= IDLE;
         ptr   <= '0;
         win   <= '0;
         ls    <= 1'b0;
         lr    <= 1'b0;
         lidx  <= '0;
         gnt   <= '0;
         ack   <= '0;
         q     <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         win   <= win_n;
         ls    <= ls_n;
         lr    <= lr_n;
         lidx  <= lidx_n;
         gnt   <= gnt_n;
         ack   <= ack_n;
         q     <= q_n;
         err   <= err_n;
      end
   end

endmodule

// File: tb/tb_srff_bank_ctrl.sv
// tb_srff_bank_ctrl: table, directed and random checks of srff_bank_ctrl
// against a transaction-level flag-bank model (NFLAG=6 to reach out-of-range).
module tb_srff_bank_ctrl;

   localparam int NREQ  = 4;
   localparam int NFLAG = 6;
   localparam int IW    = 3;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic [3:0]  req = '0;
   logic [3:0]  cmd_s = '0;
   logic [3:0]  cmd_r = '0;
   logic [11:0] cmd_idx = '0;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic [5:0]  q;
   logic        err;
   logic        busy;

   int tests = 0;
   int fails = 0;

   logic [5:0] m_q;
   logic       m_err;
   int         m_ptr;
   logic       cs [4];
   logic       cr [4];
   logic [2:0] ci [4];
   int         order [$];

   typedef struct {
      int         who;
      logic       s;
      logic       r;
      logic [2:0] idx;
      logic [5:0] exp_q;
   } vec_t;

   vec_t tbl [8];

   srff_bank_ctrl #(
      .NREQ (NREQ),
      .NFLAG(NFLAG),
      .IW   (IW)
   ) dut (
      .clk    (clk),
      .res    (res),
      .req    (req),
      .cmd_s  (cmd_s),
      .cmd_r  (cmd_r),
      .cmd_idx(cmd_idx),
      .gnt    (gnt),
      .ack    (ack),
      .q      (q),
      .err    (err),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_cmd(input int i, input logic s, input logic r,
                          input logic [2:0] idx);
      cs[i] = s;
      cr[i] = r;
      ci[i] = idx;
      cmd_s[i] = s;
      cmd_r[i] = r;
      cmd_idx[i*3 +: 3] = idx;
   endtask

   function automatic int m_pick(input logic [3:0] pend);
      for (int k = 0; k < 4; k++) begin
         if (pend[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      end
      return 0;
   endfunction

   // Flag-bank rules applied to requester i's command.
   task automatic m_apply(input int i);
      int x;
      x = int'(ci[i]);
      if (x >= NFLAG) m_err = 1'b1;
      else if (cs[i] && !cr[i]) m_q[x] = 1'b1;
      else if (!cs[i] && cr[i]) m_q[x] = 1'b0;
      else if (cs[i] && cr[i]) begin
`ifdef SRFF_CTRL_TOGGLE_EN
         m_q[x] = ~m_q[x];
`else
         m_err = 1'b1;
`endif
      end
   endtask

   task automatic do_reset();
      res = 1'b1;
      repeat (3) begin
         req = 4'($urandom);
         cmd_s = 4'($urandom);
         cmd_r = 4'($urandom);
         cmd_idx = 12'($urandom);
         step();
         chk("rst_outs", {gnt, ack, q, err, busy}, 0);
      end
      req = '0;
      res = 1'b0;
      m_q = '0;
      m_err = 1'b0;
      m_ptr = 0;
      step();
   endtask

   // Serve every requester in mask, each released after ack plus 0..hold_max cycles.
   task automatic run_round(input logic [3:0] mask, input int hold_max);
      logic [3:0] pend;
      logic [3:0] oh;
      int w;
      int h;
      pend = mask;
      req = mask;
      while (pend != 0) begin
         w = m_pick(pend);
         oh = 4'(1 << w);
         step();
         chk("gnt", gnt, oh);
         chk("ack_pre", ack, 0);
         chk("busy", busy, 1);
         cmd_s[w] = 1'($urandom);
         cmd_r[w] = 1'($urandom);
         cmd_idx[w*3 +: 3] = 3'($urandom);
         step();
         m_apply(w);
         chk("ack", ack, oh);
         chk("gnt_hold", gnt, oh);
         chk("q", q, m_q);
         chk("err", err, m_err);
         h = $urandom_range(0, hold_max);
         repeat (h) begin
            step();
            chk("ack_stay", ack, oh);
         end
         req[w] = 1'b0;
         pend[w] = 1'b0;
         m_ptr = (w + 1) % 4;
         order.push_back(w);
         step();
         chk("rel_gnt_ack", {gnt, ack}, 0);
         chk("rel_busy", busy, 0);
      end
   endtask

   initial begin
      int ord;
      tbl[0] = '{0, 1'b1, 1'b0, 3'd3, 6'h08};
      tbl[1] = '{2, 1'b0, 1'b1, 3'd3, 6'h00};
      tbl[2] = '{1, 1'b1, 1'b0, 3'd5, 6'h20};
      tbl[3] = '{3, 1'b0, 1'b0, 3'd5, 6'h20};
      tbl[4] = '{0, 1'b1, 1'b0, 3'd0, 6'h21};
      tbl[5] = '{3, 1'b0, 1'b1, 3'd5, 6'h01};
      tbl[6] = '{2, 1'b1, 1'b0, 3'd4, 6'h11};
      tbl[7] = '{1, 1'b0, 1'b1, 3'd0, 6'h10};

      do_reset();

      for (int i = 0; i < 8; i++) begin
         set_cmd(tbl[i].who, tbl[i].s, tbl[i].r, tbl[i].idx);
         run_round(4'(1 << tbl[i].who), 0);
         chk("tbl_q", q, tbl[i].exp_q);
         chk("tbl_err", err, 0);
      end

      // Winner drops req while in GRANT: command applied, quick release.
      set_cmd(3, 1'b1, 1'b0, 3'd1);
      req = 4'b1000;
      step();
      chk("pv_gnt", gnt, 4'b1000);
      req = '0;
      step();
      m_apply(3);
      m_ptr = 0;
      chk("pv_ack", ack, 4'b1000);
      chk("pv_q", q, 6'h12);
      step();
      chk("pv_rel", {gnt, ack, busy}, 0);

      // Round-robin from ptr=0, then from ptr=2.
      do_reset();
      order.delete();
      for (int i = 0; i < 4; i++) set_cmd(i, 1'b1, 1'b0, 3'(i));
      run_round(4'hF, 0);
      ord = (order[0] << 12) | (order[1] << 8) | (order[2] << 4) | order[3];
      chk("rr_cnt", order.size(), 4);
      chk("rr_order", ord, 32'h0123);
      chk("rr_q", q, 6'h0F);
      set_cmd(1, 1'b0, 1'b0, 3'd0);
      run_round(4'b0010, 0);
      order.delete();
      for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 1'b1, 3'(i));
      run_round(4'hF, 1);
      ord = (order[0] << 12) | (order[1] << 8) | (order[2] << 4) | order[3];
      chk("rr2_order", ord, 32'h2301);
      chk("rr2_q", q, 6'h00);

      // Asynchronous reset while in RELEASE.
      set_cmd(0, 1'b1, 1'b0, 3'd2);
      req = 4'b0001;
      step();
      step();
      chk("mid_ack", ack, 4'b0001);
      res = 1'b1;
      #1;
      chk("mid_rst", {gnt, ack, q, err, busy}, 0);
      do_reset();

      // Illegal s=r=1 command.
      set_cmd(0, 1'b1, 1'b1, 3'd5);
      run_round(4'b0001, 0);
`ifdef SRFF_CTRL_TOGGLE_EN
      chk("ill_q", q, 6'h20);
      chk("ill_err", err, 0);
      set_cmd(0, 1'b1, 1'b1, 3'd5);
      run_round(4'b0001, 0);
      chk("ill_q2", q, 6'h00);
`else
      chk("ill_q", q, 6'h00);
      chk("ill_err", err, 1);
      set_cmd(1, 1'b1, 1'b0, 3'd1);
      run_round(4'b0010, 0);
      chk("ill_sticky", err, 1);
      chk("ill_q2", q, 6'h02);
`endif

      // Out-of-range index.
      do_reset();
      set_cmd(1, 1'b1, 1'b0, 3'd7);
      run_round(4'b0010, 0);
      chk("oor_q", q, 6'h00);
      chk("oor_err", err, 1);

      // Random traffic against the model.
      do_reset();
      repeat (40) begin
         logic [3:0] mask;
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
               set_cmd(i, 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
            end
         end
         run_round(mask, 2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
